// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types, defaults and helpers for sram_arbiter
//
// Contents:
//   NUM_PORTS                       number of requesters (instruction side = 0, data side = 1)
//   DEF_ADDR_W/DEF_DATA_W/DEF_DEPTH default geometry of the 512x64 macro
//   arb_state_e                     controller state (INIT sweep, RUN arbitration)
//   byte_bweb()                     expands one byte strobe to eight active-low bit enables
package sram_arbiter_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH  = 512;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_e;

  // The macro's BWEB is per bit and active low; a set strobe enables the whole byte.
  function automatic logic [7:0] byte_bweb(input logic strobe);
    return {8{~strobe}};
  endfunction

endpackage

// File: rtl/sram_arbiter_rr.sv
// rtl/sram_arbiter_rr.sv - two-way round-robin picker
//
// Ports:
//   valid[1:0]  in   requests eligible for a grant this cycle
//   last        in   port granted most recently (0 or 1)
//   grant[1:0]  out  one-hot grant, all zero when nothing is valid
module sram_arbiter_rr
  import sram_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 last,
  output logic [NUM_PORTS-1:0] grant
);

  always_comb begin
    grant = '0;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the port that did not win last time goes first.
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one single-port SRAM macro between two requesters
//
// Optional feature: define SRAM_ARBITER_INIT_EN to zero-fill the array after reset.
//
// Ports:
//   clock, reset                      clock shared with the macro; synchronous active-high reset
//   req_valid/req_ready/req_write     per-port request handshake and direction (1 = write)
//   req_addr0/1, req_wdata0/1         per-port word address and write data
//   req_wmask0/1                      per-port byte strobes, 1 = write byte
//   resp_valid[1:0], resp_rdata       read response one cycle after the grant; data shared
//   init_done                         array usable (controller in RUN)
//   sram_CEB/WEB/BWEB/A/D, sram_Q     macro pins (enables active low)
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_PORTS-1:0]   req_valid,
  output logic [NUM_PORTS-1:0]   req_ready,
  input  logic [NUM_PORTS-1:0]   req_write,
  input  logic [ADDR_W-1:0]      req_addr0,
  input  logic [ADDR_W-1:0]      req_addr1,
  input  logic [DATA_W-1:0]      req_wdata0,
  input  logic [DATA_W-1:0]      req_wdata1,
  input  logic [DATA_W/8-1:0]    req_wmask0,
  input  logic [DATA_W/8-1:0]    req_wmask1,
  output logic [NUM_PORTS-1:0]   resp_valid,
  output logic [DATA_W-1:0]      resp_rdata,
  output logic                   init_done,
  output logic                   sram_CEB,
  output logic                   sram_WEB,
  output logic [DATA_W-1:0]      sram_BWEB,
  output logic [ADDR_W-1:0]      sram_A,
  output logic [DATA_W-1:0]      sram_D,
  input  logic [DATA_W-1:0]      sram_Q
);

  localparam int MASK_W = DATA_W / 8;

  if ((DATA_W % 8) != 0 || DEPTH != (1 << ADDR_W)) begin : g_param_check
    $error("sram_arbiter: DATA_W must be a multiple of 8 and DEPTH must equal 2**ADDR_W");
  end

  arb_state_e           state_q, state_d;
  logic                 last_q, last_d;
  logic                 run;
  logic                 sel;
  logic [NUM_PORTS-1:0] grant;
  logic [DATA_W-1:0]    bweb0, bweb1;

`ifdef SRAM_ARBITER_INIT_EN
  // One bit wider than the address so the terminal compare is unambiguous.
  logic [ADDR_W:0]      init_cnt_q, init_cnt_d;
`endif

  assign run       = (state_q == RUN);
  assign init_done = run;

  // Requests are simply masked off outside RUN; the requester keeps valid high and
  // is served once the sweep finishes.
  sram_arbiter_rr u_rr (
    .valid (req_valid & {NUM_PORTS{run}}),
    .last  (last_q),
    .grant (grant)
  );

  assign req_ready = grant;
  assign sel       = grant[1];

  for (genvar k = 0; k < MASK_W; k++) begin : g_bweb
    assign bweb0[8*k +: 8] = byte_bweb(req_wmask0[k]);
    assign bweb1[8*k +: 8] = byte_bweb(req_wmask1[k]);
  end

  // Next state / init counter.
  always_comb begin
    state_d = state_q;
`ifdef SRAM_ARBITER_INIT_EN
    init_cnt_d = init_cnt_q;
    if (state_q == INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (init_cnt_q == (ADDR_W+1)'(DEPTH - 1)) begin
        state_d = RUN;
      end
    end
`endif
  end

  // last_q = 1 means port 1 won the most recent grant.
  always_comb begin
    last_d = last_q;
    if (|grant) begin
      last_d = sel;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
`ifdef SRAM_ARBITER_INIT_EN
      state_q    <= INIT;
      init_cnt_q <= '0;
`else
      state_q    <= RUN;
`endif
      last_q     <= 1'b1;
      resp_valid <= '0;
    end else begin
      state_q    <= state_d;
`ifdef SRAM_ARBITER_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
      last_q     <= last_d;
      resp_valid <= grant & ~req_write;
    end
  end

  // Macro pin mux: sweep write, granted access, or idle.
  always_comb begin
    sram_CEB  = 1'b1;
    sram_WEB  = 1'b1;
    sram_BWEB = '1;
    sram_A    = '0;
    sram_D    = '0;
`ifdef SRAM_ARBITER_INIT_EN
    if (state_q == INIT) begin
      sram_CEB  = 1'b0;
      sram_WEB  = 1'b0;
      sram_BWEB = '0;
      sram_A    = init_cnt_q[ADDR_W-1:0];
      sram_D    = '0;
    end else
`endif
    if (|grant) begin
      sram_CEB = 1'b0;
      sram_A   = sel ? req_addr1 : req_addr0;
      if (req_write[sel]) begin
        // An all-zero mask still selects the macro; BWEB keeps every bit unchanged.
        sram_WEB  = 1'b0;
        sram_D    = sel ? req_wdata1 : req_wdata0;
        sram_BWEB = sel ? bweb1 : bweb0;
      end
    end
  end

  // Macro output is already registered by the read cycle; pass it straight through.
  assign resp_rdata = sram_Q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with a behavioural SRAM and reference model
module tb_sram_arbiter;

  logic        clock;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [8:0]  req_addr0, req_addr1;
  logic [63:0] req_wdata0, req_wdata1;
  logic [7:0]  req_wmask0, req_wmask1;
  logic [1:0]  resp_valid;
  logic [63:0] resp_rdata;
  logic        init_done;
  logic        sram_CEB, sram_WEB;
  logic [63:0] sram_BWEB;
  logic [8:0]  sram_A;
  logic [63:0] sram_D;
  logic [63:0] sram_Q;

  sram_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .req_wmask0 (req_wmask0),
    .req_wmask1 (req_wmask1),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .sram_CEB   (sram_CEB),
    .sram_WEB   (sram_WEB),
    .sram_BWEB  (sram_BWEB),
    .sram_A     (sram_A),
    .sram_D     (sram_D),
    .sram_Q     (sram_Q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef SRAM_ARBITER_INIT_EN
  localparam bit INIT_ON = 1'b1;
`else
  localparam bit INIT_ON = 1'b0;
`endif

  // Behavioural single-port macro: registered read, bit-masked write.
  logic [63:0] sram_mem [512];
  always @(posedge clock) begin
    if (!sram_CEB) begin
      if (!sram_WEB) sram_mem[sram_A] <= (sram_mem[sram_A] & sram_BWEB) | (sram_D & ~sram_BWEB);
      else           sram_Q <= sram_mem[sram_A];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state.
  logic [63:0] m_mem   [512];
  logic [63:0] m_known [512];
  int          m_last;
  bit          m_run;
  int          m_cnt;
  logic [1:0]  m_pend;
  logic [63:0] m_pdata, m_pknown;
  bit          chk_en = 1'b0;

  always @(negedge clock) begin
    int          g;
    int          a;
    logic [1:0]  vv;
    logic [1:0]  e_ready;
    logic        e_ceb, e_web;
    logic [63:0] e_bweb, e_d, wd;
    logic [7:0]  wm;
    bit          d_chk;
    if (chk_en) begin
      vv = m_run ? req_valid : 2'b00;
      if (vv == 2'b11)      g = 1 - m_last;
      else if (vv == 2'b01) g = 0;
      else if (vv == 2'b10) g = 1;
      else                  g = -1;
      e_ready = (g < 0) ? 2'b00 : (2'b01 << g);
      a  = (g == 1) ? int'(req_addr1) : int'(req_addr0);
      wd = (g == 1) ? req_wdata1 : req_wdata0;
      wm = (g == 1) ? req_wmask1 : req_wmask0;

      e_ceb = 1'b1; e_web = 1'b1; e_bweb = '1; e_d = '0; d_chk = 1'b1;
      if (!m_run) begin
        e_ceb = 1'b0; e_web = 1'b0; e_bweb = '0; a = m_cnt;
      end else if (g >= 0) begin
        e_ceb = 1'b0;
        if (req_write[g]) begin
          e_web = 1'b0;
          e_d   = wd;
          for (int b = 0; b < 64; b++) e_bweb[b] = ~wm[b/8];
        end else begin
          d_chk = 1'b0;
        end
      end else begin
        a = 0;
      end

      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("resp_valid", 64'(resp_valid), 64'(m_pend));
      chk("init_done", 64'(init_done), 64'(m_run));
      chk("sram_CEB", 64'(sram_CEB), 64'(e_ceb));
      if (!e_ceb) begin
        chk("sram_WEB", 64'(sram_WEB), 64'(e_web));
        chk("sram_BWEB", sram_BWEB, e_bweb);
      end
      chk("sram_A", 64'(sram_A), 64'(a));
      if (d_chk) chk("sram_D", sram_D, e_d);
      if (m_pend != 2'b00 && m_pknown != 64'd0)
        chk("resp_rdata", resp_rdata & m_pknown, m_pdata & m_pknown);

      // Effect of this cycle's access on the array.
      if (!e_ceb && !e_web) begin
        for (int b = 0; b < 64; b++) begin
          if (!e_bweb[b]) begin
            m_mem[a][b]   = e_d[b];
            m_known[a][b] = 1'b1;
          end
        end
      end

      if (reset) begin
        m_last = 1; m_pend = 2'b00; m_run = !INIT_ON; m_cnt = 0;
      end else begin
        m_pend = 2'b00;
        if (g >= 0 && !req_write[g]) begin
          m_pend   = e_ready;
          m_pdata  = m_mem[a];
          m_pknown = m_known[a];
        end
        if (g >= 0) m_last = g;
        if (!m_run) begin
          if (m_cnt == 511) m_run = 1'b1;
          else              m_cnt = m_cnt + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [1:0] w, input logic [8:0] a0,
                         input logic [8:0] a1, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [7:0] m0, input logic [7:0] m1);
    req_valid = v; req_write = w; req_addr0 = a0; req_addr1 = a1;
    req_wdata0 = d0; req_wdata1 = d1; req_wmask0 = m0; req_wmask1 = m1;
  endtask

  task automatic idle();
    set_req(2'b00, 2'b00, 9'd0, 9'd0, 64'd0, 64'd0, 8'd0, 8'd0);
  endtask

  // Counts cycles with init_done low; returns on the first cycle it is high.
  task automatic wait_init(output int cnt);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      if (init_done) return;
      cnt++;
    end
    chk("init_timeout", 64'(init_done), 64'd1);
  endtask

  logic [1:0] seen_ready [5];
  logic [1:0] seen_resp  [5];
  int         ic;

  initial begin
    for (int i = 0; i < 512; i++) begin
      sram_mem[i] = {32'hDEADBEEF, 32'(i)};
      m_mem[i]    = '0;
      m_known[i]  = '0;
    end
    sram_Q = '0;
    m_last = 1; m_run = !INIT_ON; m_cnt = 0; m_pend = 2'b00; m_pdata = '0; m_pknown = '0;
    reset = 1'b1;
    idle();
    step();
    chk_en = 1'b1;
    repeat (3) step();
    @(negedge clock);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);

    // Hold-off: port 0 reads 0x1FF while the array is still being swept.
    step();
    set_req(2'b01, 2'b00, 9'h1FF, 9'd0, 64'd0, 64'd0, 8'd0, 8'd0);
    reset = 1'b0;
    if (INIT_ON) begin
      for (int i = 0; i < 300; i++) begin
        @(negedge clock);
        if (sram_A == 9'd100) break;
      end
      chk("sweep_at_100", 64'(sram_A), 64'd100);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
    end
    wait_init(ic);
    chk("init_cycles", 64'(ic), INIT_ON ? 64'd512 : 64'd0);
    chk("holdoff_grant", 64'(req_ready), 64'd1);
    step();
    idle();
    @(negedge clock);
    chk("holdoff_resp", 64'(resp_valid), 64'd1);
    if (INIT_ON) chk("zero_1ff", resp_rdata, 64'd0);
    step();

    // Port 1 write then read-back on the next cycle.
    set_req(2'b10, 2'b10, 9'd0, 9'h005, 64'd0, 64'h1122334455667788, 8'd0, 8'hFF);
    @(negedge clock);
    chk("wr5_ready", 64'(req_ready), 64'd2);
    step();
    set_req(2'b10, 2'b00, 9'd0, 9'h005, 64'd0, 64'd0, 8'd0, 8'd0);
    step();
    idle();
    @(negedge clock);
    chk("rd5_valid", 64'(resp_valid), 64'd2);
    chk("rd5_data", resp_rdata, 64'h1122334455667788);
    step();

    // Partial write on port 0.
    set_req(2'b01, 2'b01, 9'h010, 9'd0, 64'd0, 64'd0, 8'hFF, 8'd0);
    step();
    set_req(2'b01, 2'b01, 9'h010, 9'd0, 64'hFFFFFFFFFFFFFFFF, 64'd0, 8'h0F, 8'd0);
    @(negedge clock);
    chk("partial_bweb", sram_BWEB, 64'hFFFFFFFF00000000);
    step();
    set_req(2'b01, 2'b00, 9'h010, 9'd0, 64'd0, 64'd0, 8'd0, 8'd0);
    step();
    idle();
    @(negedge clock);
    chk("partial_valid", 64'(resp_valid), 64'd1);
    chk("partial_data", resp_rdata, 64'h00000000FFFFFFFF);
    step();

    // Contention: a lone port 1 read first, then both ports valid for four cycles.
    set_req(2'b10, 2'b00, 9'h010, 9'h005, 64'd0, 64'd0, 8'd0, 8'd0);
    step();
    set_req(2'b11, 2'b00, 9'h010, 9'h005, 64'd0, 64'd0, 8'd0, 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      seen_ready[i] = req_ready;
      seen_resp[i]  = resp_valid;
      step();
    end
    idle();
    @(negedge clock);
    seen_resp[4] = resp_valid;
    chk("tie_g0", 64'(seen_ready[0]), 64'd1);
    chk("tie_g1", 64'(seen_ready[1]), 64'd2);
    chk("tie_g2", 64'(seen_ready[2]), 64'd1);
    chk("tie_g3", 64'(seen_ready[3]), 64'd2);
    chk("tie_r0", 64'(seen_resp[0]), 64'd2);
    chk("tie_r1", 64'(seen_resp[1]), 64'd1);
    chk("tie_r2", 64'(seen_resp[2]), 64'd2);
    chk("tie_r3", 64'(seen_resp[3]), 64'd1);
    chk("tie_r4", 64'(seen_resp[4]), 64'd2);
    step();

    // Reset while a read response is pending.
    set_req(2'b01, 2'b00, 9'h010, 9'd0, 64'd0, 64'd0, 8'd0, 8'd0);
    step();
    idle();
    reset = 1'b1;
    @(negedge clock);
    chk("rstrd_pending", 64'(resp_valid), 64'd1);
    step();
    @(negedge clock);
    chk("rstrd_cleared", 64'(resp_valid), 64'd0);
    step();
    reset = 1'b0;
    wait_init(ic);
    chk("reinit_cycles", 64'(ic), INIT_ON ? 64'd512 : 64'd0);
    step();

    // Randomised traffic on a small address window so reads hit earlier writes.
    for (int i = 0; i < 2000; i++) begin
      set_req(2'($urandom), 2'($urandom), 9'($urandom_range(0, 15)), 9'($urandom_range(0, 15)),
              {$urandom, $urandom}, {$urandom, $urandom},
              ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
              ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
      step();
    end
    idle();
    repeat (3) step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Controller that shares one 512x64 single-port SRAM macro between two requesters: an instruction-side port (port 0) and a data-side port (port 1). It arbitrates round-robin and converts valid/ready read/write requests into the macro's active-low CEB/WEB/BWEB pins. Read data is returned with a fixed one-cycle latency. Optionally, it zero-fills the array after reset. It sits between the cache/pipeline requesters and the SRAM macro instance.

## Interface
Parameters:
- `ADDR_W`, 9, word address width
- `DATA_W`, 64, word width; must be a multiple of 8
- `DEPTH`, 512, number of words (2^ADDR_W)

Ports:
- `clock`  in  1  single clock; macro shares it
- `reset`  in  1  synchronous, active-high
- `req_valid[1:0]`  in  2  request valid per port
- `req_ready[1:0]`  out  2  request accepted this cycle
- `req_write[1:0]`  in  2  1 = write, 0 = read
- `req_addr0`, `req_addr1`  in  ADDR_W  word address
- `req_wdata0`, `req_wdata1`  in  DATA_W  write data
- `req_wmask0`, `req_wmask1`  in  DATA_W/8  byte strobe, 1 = write byte
- `resp_valid[1:0]`  out  2  read data valid
- `resp_rdata`  out  DATA_W  read data (shared; qualified by `resp_valid`)
- `init_done`  out  1  array usable
- `sram_CEB`, `sram_WEB`  out  1  macro chip/write enable, active low
- `sram_BWEB`  out  DATA_W  macro bit write enable, active low
- `sram_A`  out  ADDR_W  macro address
- `sram_D`  out  DATA_W  macro write data
- `sram_Q`  in  DATA_W  macro read data

## Operation
- States: `INIT` (only when the macro below is defined) and `RUN`. Reset enters `INIT` at address 0 if the macro is defined, otherwise `RUN`.
- Arbitration happens only in `RUN`.
  - One port valid: that port is granted.
  - Both valid: the port not granted last is granted.
  - `last` resets to 1, so port 0 wins the first tie.
  - `last` updates only on a grant.
- `req_ready[i]` = grant to i. It is combinational from `req_valid` and `last`. A request completes on the cycle where valid and ready are both high. Requesters must not make `req_valid` depend on `req_ready`.
- Granted access drives the macro:
  - `sram_CEB` = 0, `sram_A` = addr.
  - Write: `sram_WEB` = 0, `sram_D` = wdata, and `sram_BWEB[8k+7:8k]` = ~{8{wmask[k]}}.
  - Read: `sram_WEB` = 1, `sram_BWEB` all 1.
- Write with an all-zero mask: CEB is still asserted and no bits change.
- Idle pins: CEB = 1, WEB = 1, BWEB all 1, A = 0, D = 0.
- Read response:
  - `resp_valid[i]` is a register set the cycle after a read grant to i.
  - `resp_rdata` = `sram_Q` passed through.
  - Writes produce no response.
  - There is no response backpressure; the requester must sink it.
- Back-to-back reads from the same port on consecutive cycles are allowed. A read to an address written in the immediately preceding cycle returns the new data.

## Timing
- Reset values: `req_ready` = 0, `resp_valid` = 0, `last` = 1.
- `init_done`: 0 during `INIT`; 1 in `RUN`.
- Read latency: grant in cycle N gives `resp_valid` in N+1. Throughput is one access per cycle total.
- Reset asserted mid-`INIT` or mid-read: the pending `resp_valid` is cleared next cycle, and the `INIT` sweep restarts at address 0.
- Requests presented during `INIT` are held off (`req_ready` = 0) and are not lost.

## Configuration
- `SRAM_ARBITER_INIT_EN` defined:
  - `INIT` writes zero to addresses 0..DEPTH-1, one per cycle, with BWEB all 0 and D = 0.
  - The counter is ADDR_W+1 bits wide.
  - After writing DEPTH-1, the block enters `RUN`. `init_done` rises DEPTH cycles after reset deasserts.
- Not defined:
  - No sweep; the array contents are undefined.
  - `init_done` = 1 and arbitration is available on the first cycle after reset deasserts.

## Structure
- Shared package `sram_arbiter_pkg`:
  - state enum {INIT, RUN}
  - `NUM_PORTS` = 2
  - default `ADDR_W`/`DATA_W`/`DEPTH`
  - the function that expands a byte mask to BWEB
- Sub-module `sram_arbiter_rr`: a 2-way round-robin picker taking valid[1:0] and last, producing a grant one-hot. The top level holds the `last` register, the FSM, the init counter, the response registers and the pin muxing.

## Test plan
- Init (macro on): release reset. `init_done` is 0 for 512 cycles with a sweep on A = 0..511 and BWEB = 0. Port 0 reading addr 0x1FF after `init_done` returns 0.
- Single-port write then read: port 1 writes addr 0x005, data 0x1122334455667788, mask 0xFF. Next cycle port 1 reads 0x005. `resp_valid[1]` rises one cycle later with that data.
- Partial write: mask 0x0F with data all-F over 0. Readback is 0x00000000FFFFFFFF, and BWEB upper 32 bits are 1 during the write.
- Contention: both ports valid for 4 cycles. Grants are 0,1,0,1 and `resp_valid` alternates with one-cycle delay.
- Reset mid-sweep: assert reset at sweep address 100. After release, the sweep restarts at 0 and `init_done` rises 512 cycles later.
- Hold-off: port 0 valid during `INIT`. `req_ready[0]` stays 0 until `RUN`, then the request is granted on the first `RUN` cycle.
